player_collision_manager: RTL and testbench
===========================================

Name: player_collision_manager

Overview:
- Sits between the player sprite logic and the meteor controller, downstream of meteor positions/state and upstream of meteor movement gating.
- Each cycle it tests the player box against all 6 meteor boxes and issues one-cycle `deactivate_meteors` pulses for hits.
- It owns the game-state FSM: idle, playing, invulnerable and game over. It tracks lives and score (meteors dodged) and drives `game_enable` to the meteor controller.

Parameters:
- PLAYER_W, 32, player box width in pixels
- PLAYER_H, 16, player box height in pixels
- METEOR_SIZE, 30, meteor box edge length in pixels (square)
- START_LIVES, 3, lives loaded on game start (1..3)
- INVULN_CYCLES, 60, length of the post-hit invulnerability window in clk cycles (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle start/restart request
- player_x  in  10  player box left edge
- player_y  in  9  player box top edge
- meteor_x  in  10 x [5:0]  meteor left edges (unpacked array)
- meteor_y  in  9 x [5:0]  meteor top edges (unpacked array)
- meteor_active  in  6  meteor valid flags
- meteor_passed  in  1  one-cycle pulse: a meteor left the bottom of the screen
- game_enable  out  1  run enable to the meteor controller
- deactivate_meteors  out  6  one-cycle kill pulses per meteor
- lives  out  2  remaining lives
- score  out  14  meteors dodged, saturating
- game_over  out  1  high while in GAME_OVER
- invuln  out  1  high while in INVULN (drives player blink)

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, game_enable=0, deactivate_meteors=0, lives=START_LIVES, score=0, game_over=0, invuln=0, invulnerability counter=0. Reset mid-game returns to IDLE in one cycle.
- Overlap test (combinational), for each i:
  - hit[i] = meteor_active[i] & (mx < px+PLAYER_W) & (px < mx+METEOR_SIZE) & (my < py+PLAYER_H) & (py < my+METEOR_SIZE).
  - Compares are strict, so edge-touching is not a hit.
  - All sums are computed at 11 bits, so there is no wrap.
  - Inactive meteors (including off-screen 700/500) never hit.
- All outputs are registered. Latency is 1 cycle from the input sample to deactivate_meteors / lives / state.
- IDLE:
  - game_enable=0.
  - start -> PLAYING; load lives=START_LIVES and score=0.
- PLAYING:
  - game_enable=1.
  - If |hit: deactivate_meteors<=hit for exactly 1 cycle, and lives<=lives-1.
  - Several simultaneous hits cost one life only, but all hit meteors are deactivated.
  - If lives==1 at the hit -> GAME_OVER with lives<=0. Otherwise -> INVULN with counter<=INVULN_CYCLES-1.
- INVULN:
  - game_enable=1, invuln=1.
  - Hits are ignored: no deactivation and no life loss.
  - Counter decrements each cycle; counter==0 -> PLAYING.
- GAME_OVER:
  - game_enable=0, game_over=1; score and lives hold.
  - start -> PLAYING with lives=START_LIVES, score=0, game_over cleared.
- start is ignored in PLAYING and INVULN.
- Score:
  - meteor_passed while in PLAYING or INVULN -> score+1, saturating at 16383.
  - meteor_passed in IDLE or GAME_OVER is ignored.
  - A pass and a hit in the same cycle are both applied, including on the fatal hit (score increments, then GAME_OVER).
- deactivate_meteors is 0 in every cycle not described above. It never asserts on two consecutive cycles, because a hit always leaves PLAYING.

Optional Feature:
- Macro: EXTRA_LIFE_EN.
- Defined:
  - When score increments to a nonzero multiple of 50 and lives<3, lives+1.
  - If a life is lost in the same cycle, the two cancel and lives is unchanged.
  - If that cancelling hit is also the fatal hit (lives==1), the game stays alive: lives remains 1 and the state goes to INVULN instead of GAME_OVER.
- Not defined: lives changes only by hits and by start.

Test Plan:
- Reset, then start pulse -> next cycle game_enable=1, lives=3, score=0, state PLAYING.
- Player (300,440), meteor0 active at (310,430) -> next cycle deactivate_meteors=6'b000001 for 1 cycle, lives=2, invuln=1 for 60 cycles, then PLAYING.
- Meteor0 at (332,430), exactly edge-touching on the right -> no deactivation, lives stays 3. Meteor at (331,430) -> hit.
- Meteors 1 and 4 both overlapping in the same cycle -> deactivate_meteors=6'b010010, lives drops by 1 only.
- Three separate hits, each after invulnerability expires -> lives 3->2->1->0. game_over=1, game_enable=0; a meteor_passed pulse leaves score unchanged; start restarts with lives=3, score=0.
- 50 meteor_passed pulses with lives=2 -> score=50; with EXTRA_LIFE_EN lives=3, without it lives=2. Force score=16383 -> a further pass keeps 16383.

Source files
------------

// File: rtl/player_collision_manager.sv
// player_collision_manager: player vs meteor overlap test, game-state FSM,
// lives/score tracking and meteor-controller run enable.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle start/restart request
//   player_x, player_y    player box top-left corner
//   meteor_x, meteor_y    per-meteor box top-left corners (6 entries)
//   meteor_active         per-meteor valid flags
//   meteor_passed         pulse: a meteor left the bottom of the screen
//   game_enable           run enable to the meteor controller
//   deactivate_meteors    one-cycle kill pulse per hit meteor
//   lives, score          remaining lives, saturating dodge count
//   game_over, invuln     high while in GAME_OVER / INVULN
//
// Optional feature: define EXTRA_LIFE_EN to award a life every 50 points.
module player_collision_manager #(
   parameter int PLAYER_W      = 32,
   parameter int PLAYER_H      = 16,
   parameter int METEOR_SIZE   = 30,
   parameter int START_LIVES   = 3,
   parameter int INVULN_CYCLES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] player_x,
   input  logic [8:0] player_y,
   input  logic [9:0] meteor_x [5:0],
   input  logic [8:0] meteor_y [5:0],
   input  logic [5:0] meteor_active,
   input  logic       meteor_passed,
   output logic       game_enable,
   output logic [5:0] deactivate_meteors,
   output logic [1:0] lives,
   output logic [13:0] score,
   output logic       game_over,
   output logic       invuln
);

   typedef enum logic [1:0] {
      IDLE,
      PLAYING,
      INVULN,
      GAME_OVER
   } state_t;

   localparam int CW =
      (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(INVULN_CYCLES - 1);
   localparam logic [10:0] PW = 11'(PLAYER_W);
   localparam logic [10:0] PH = 11'(PLAYER_H);
   localparam logic [10:0] MS = 11'(METEOR_SIZE);
   localparam logic [1:0] LIVES0 = 2'(START_LIVES);
   localparam logic [13:0] SCORE_MAX = 14'h3FFF;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [5:0]    hit;
   logic          any_hit;
   logic          running;
   logic          score_inc;
   logic [13:0]   score_nxt;
   logic          bonus;

   // 11-bit sums so the far edges never wrap.
   always_comb begin
      hit = '0;
      for (int i = 0; i < 6; i++) begin
         hit[i] = meteor_active[i]
            & ({1'b0, meteor_x[i]} < {1'b0, player_x} + PW)
            & ({1'b0, player_x} < {1'b0, meteor_x[i]} + MS)
            & ({2'b0, meteor_y[i]} < {2'b0, player_y} + PH)
            & ({2'b0, player_y} < {2'b0, meteor_y[i]} + MS);
      end
   end

   assign any_hit   = |hit;
   assign running   = (state == PLAYING) || (state == INVULN);
   assign score_nxt = score + 14'd1;
   assign score_inc = running && meteor_passed
                      && (score != SCORE_MAX);

`ifdef EXTRA_LIFE_EN
   assign bonus = score_inc && (lives != 2'd3)
                  && ((score_nxt % 14'd50) == 14'd0);
`else
   assign bonus = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         cnt                <= '0;
         game_enable        <= 1'b0;
         deactivate_meteors <= '0;
         lives              <= LIVES0;
         score              <= '0;
         game_over          <= 1'b0;
         invuln             <= 1'b0;
      end else begin
         deactivate_meteors <= '0;
         if (score_inc)
            score <= score_nxt;
         unique case (state)
            IDLE, GAME_OVER: begin
               if (start) begin
                  state       <= PLAYING;
                  lives       <= LIVES0;
                  score       <= '0;
                  game_enable <= 1'b1;
                  game_over   <= 1'b0;
               end
            end
            PLAYING: begin
               if (any_hit) begin
                  deactivate_meteors <= hit;
                  // A bonus life cancels the loss, even a fatal one.
                  if (!bonus && lives == 2'd1) begin
                     state       <= GAME_OVER;
                     lives       <= 2'd0;
                     game_enable <= 1'b0;
                     game_over   <= 1'b1;
                  end else begin
                     if (!bonus)
                        lives <= lives - 2'd1;
                     state  <= INVULN;
                     invuln <= 1'b1;
                     cnt    <= CNT_LOAD;
                  end
               end else if (bonus) begin
                  lives <= lives + 2'd1;
               end
            end
            INVULN: begin
               if (bonus)
                  lives <= lives + 2'd1;
               if (cnt == '0) begin
                  state  <= PLAYING;
                  invuln <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               game_enable <= 1'b0;
               game_over   <= 1'b0;
               invuln      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_player_collision_manager.sv
// Bench for player_collision_manager: directed test-plan checks with
// literal expectations plus randomized traffic against a reference model.
module tb_player_collision_manager;

   localparam int PW = 32;
   localparam int PH = 16;
   localparam int MS = 30;
   localparam int L0 = 3;
   localparam int IC = 60;
`ifdef EXTRA_LIFE_EN
   localparam bit EXTRA = 1'b1;
`else
   localparam bit EXTRA = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  player_x;
   logic [8:0]  player_y;
   logic [9:0]  meteor_x [5:0];
   logic [8:0]  meteor_y [5:0];
   logic [5:0]  meteor_active;
   logic        meteor_passed;
   logic        game_enable;
   logic [5:0]  deactivate_meteors;
   logic [1:0]  lives;
   logic [13:0] score;
   logic        game_over;
   logic        invuln;

   int compared = 0;
   int failed = 0;

   player_collision_manager dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .player_x(player_x),
      .player_y(player_y),
      .meteor_x(meteor_x),
      .meteor_y(meteor_y),
      .meteor_active(meteor_active),
      .meteor_passed(meteor_passed),
      .game_enable(game_enable),
      .deactivate_meteors(deactivate_meteors),
      .lives(lives),
      .score(score),
      .game_over(game_over),
      .invuln(invuln)
   );

   always #5 clk = ~clk;

   task automatic check(string name, int act, int exp);
      compared++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference model: 0 idle, 1 playing, 2 invulnerable, 3 game over.
   int m_st = 0;
   int m_lives = 0;
   int m_score = 0;
   int m_left = 0;
   int m_deact = 0;
   bit m_ok = 0;

   function automatic int ref_hits();
      int h = 0;
      int px = int'(player_x);
      int py = int'(player_y);
      for (int i = 0; i < 6; i++) begin
         int mx = int'(meteor_x[i]);
         int my = int'(meteor_y[i]);
         if (meteor_active[i] && mx < px + PW && px < mx + MS
             && my < py + PH && py < my + MS)
            h |= (1 << i);
      end
      return h;
   endfunction

   always @(posedge clk) begin
      int h;
      int gain;
      int bonus;
      int loss;
      int net;
      h = ref_hits();
      m_deact = 0;
      if (reset) begin
         m_ok = 1;
         m_st = 0;
         m_lives = L0;
         m_score = 0;
         m_left = 0;
      end else if (m_st == 0 || m_st == 3) begin
         if (start) begin
            m_st = 1;
            m_lives = L0;
            m_score = 0;
         end
      end else begin
         gain = (meteor_passed && m_score < 16383) ? 1 : 0;
         m_score += gain;
         bonus = (EXTRA && gain == 1 && m_score % 50 == 0
                  && m_lives < 3) ? 1 : 0;
         loss = (m_st == 1 && h != 0) ? 1 : 0;
         if (loss == 1) m_deact = h;
         net = m_lives + bonus - loss;
         m_lives = net;
         if (m_st == 2) begin
            m_left--;
            if (m_left == 0) m_st = 1;
         end else if (loss == 1) begin
            if (net == 0) begin
               m_st = 3;
            end else begin
               m_st = 2;
               m_left = IC;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         check("deact", int'(deactivate_meteors), m_deact);
         check("lives", int'(lives), m_lives);
         check("score", int'(score), m_score);
         check("enable", int'(game_enable),
               (m_st == 1 || m_st == 2) ? 1 : 0);
         check("game_over", int'(game_over), (m_st == 3) ? 1 : 0);
         check("invuln", int'(invuln), (m_st == 2) ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_meteors();
      for (int i = 0; i < 6; i++) begin
         meteor_x[i] = 10'd700;
         meteor_y[i] = 9'd500;
      end
      meteor_active = '0;
   endtask

   task automatic do_reset_start();
      start = 1'b0;
      meteor_passed = 1'b0;
      clear_meteors();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic hit0();
      meteor_x[0] = 10'd310;
      meteor_y[0] = 9'd430;
      meteor_active = 6'b000001;
      tick();
      clear_meteors();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int x;
      int y;
      reset = 1'b1;
      start = 1'b0;
      meteor_passed = 1'b0;
      player_x = 10'd300;
      player_y = 9'd440;
      clear_meteors();
      tick();
      tick();
      check("rst_lives", int'(lives), 3);
      check("rst_enable", int'(game_enable), 0);
      check("rst_score", int'(score), 0);
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_enable", int'(game_enable), 1);
      check("start_lives", int'(lives), 3);

      hit0();
      check("hit_deact", int'(deactivate_meteors), 1);
      check("hit_lives", int'(lives), 2);
      check("hit_invuln", int'(invuln), 1);
      tick();
      check("hit_pulse", int'(deactivate_meteors), 0);
      repeat (58) tick();
      check("invuln_last", int'(invuln), 1);
      tick();
      check("invuln_end", int'(invuln), 0);

      meteor_x[0] = 10'd332;
      meteor_y[0] = 9'd430;
      meteor_active = 6'b000001;
      tick();
      check("edge_deact", int'(deactivate_meteors), 0);
      check("edge_lives", int'(lives), 2);
      meteor_x[0] = 10'd331;
      tick();
      clear_meteors();
      check("edge1_deact", int'(deactivate_meteors), 1);
      check("edge1_lives", int'(lives), 1);

      do_reset_start();
      meteor_x[1] = 10'd310;
      meteor_y[1] = 9'd430;
      meteor_x[4] = 10'd290;
      meteor_y[4] = 9'd445;
      meteor_active = 6'b010010;
      tick();
      clear_meteors();
      check("multi_deact", int'(deactivate_meteors), 18);
      check("multi_lives", int'(lives), 2);

      do_reset_start();
      hit0();
      repeat (60) tick();
      hit0();
      repeat (60) tick();
      hit0();
      check("fatal_lives", int'(lives), 0);
      check("fatal_over", int'(game_over), 1);
      check("fatal_enable", int'(game_enable), 0);
      meteor_passed = 1'b1;
      tick();
      meteor_passed = 1'b0;
      check("over_score", int'(score), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_lives", int'(lives), 3);
      check("restart_over", int'(game_over), 0);

      do_reset_start();
      hit0();
      meteor_passed = 1'b1;
      repeat (50) tick();
      check("pass50_score", int'(score), 50);
      check("pass50_lives", int'(lives), EXTRA ? 3 : 2);
      repeat (16400) tick();
      meteor_passed = 1'b0;
      check("sat_score", int'(score), 16383);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(399) == 0);
         start = ($urandom_range(39) == 0);
         meteor_passed = ($urandom_range(3) == 0);
         if ($urandom_range(15) == 0) begin
            player_x = 10'($urandom_range(600));
            player_y = 9'($urandom_range(460));
         end
         meteor_active = 6'($urandom & $urandom & $urandom);
         for (int i = 0; i < 6; i++) begin
            x = int'(player_x) + $urandom_range(80) - 40;
            y = int'(player_y) + $urandom_range(80) - 40;
            meteor_x[i] = 10'((x < 0) ? 0 : x);
            meteor_y[i] = 9'((y < 0) ? 0 : (y > 511 ? 511 : y));
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, failed);
      $finish;
   end

endmodule
